// File: rtl/iir.sv
// iir: direct-form-I biquad for signed audio samples, one sample per clock.
// The output is rounded half-up, saturated and registered; the feedback state reuses the saturated output.
module iir #(
  parameter int WD_IN = 24,
  parameter int WD_OUT = 24,
  parameter int WD_COEF = 24,
  parameter int FRAC = 22,
  parameter logic signed [WD_COEF-1:0] B0 = 409495,
  parameter logic signed [WD_COEF-1:0] B1 = 818989,
  parameter logic signed [WD_COEF-1:0] B2 = 409495,
  parameter logic signed [WD_COEF-1:0] A1 = -3954428,
  parameter logic signed [WD_COEF-1:0] A2 = 1398101
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [WD_IN-1:0]  data_in,
  output logic signed [WD_OUT-1:0] data_out
);
  // Four guard bits leave headroom for five full-scale products plus the rounding offset.
  localparam int WA = (WD_IN > WD_OUT ? WD_IN : WD_OUT) + WD_COEF + 4;
  localparam logic signed [WA-1:0] HALF = WA'(1) <<< (FRAC - 1);
  localparam logic signed [WA-1:0] MAXV = WA'((64'sd1 <<< (WD_OUT - 1)) - 1);
  localparam logic signed [WA-1:0] MINV = -MAXV - 1;
  logic signed [WD_IN-1:0] r_x1, r_x2;
  logic signed [WD_OUT-1:0] r_y1, r_y2;
  logic signed [WD_IN+WD_COEF-1:0] w_p0, w_p1, w_p2;
  logic signed [WD_OUT+WD_COEF-1:0] w_pa1, w_pa2;
  logic signed [WA-1:0] w_acc, w_rnd;
  logic signed [WD_OUT-1:0] w_sat;
  always_comb begin
    w_p0 = data_in * B0;
    w_p1 = r_x1 * B1;
    w_p2 = r_x2 * B2;
    w_pa1 = r_y1 * A1;
    w_pa2 = r_y2 * A2;
    w_acc = WA'(w_p0) + WA'(w_p1) + WA'(w_p2) - WA'(w_pa1) - WA'(w_pa2);
    w_rnd = (w_acc + HALF) >>> FRAC;
    w_sat = w_rnd > MAXV ? MAXV[WD_OUT-1:0] : w_rnd < MINV ? MINV[WD_OUT-1:0] : w_rnd[WD_OUT-1:0];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x1 <= '0;
      r_x2 <= '0;
      r_y1 <= '0;
      r_y2 <= '0;
    end else begin
      r_x1 <= data_in;
      r_x2 <= r_x1;
      r_y1 <= w_sat;
      r_y2 <= r_y1;
    end
  end
  assign data_out = r_y1;
endmodule

// File: tb/tb_iir.sv
// tb_iir: directed checks of the biquad against hand-derived constants and a bit-exact
// difference-equation model (round half-up, saturate to 24 bits, saturated feedback).
module tb_iir;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic signed [23:0] data_in = '0;
  logic signed [23:0] data_out;
  int errors = 0;
  int checks = 0;
  longint mx1, mx2, my1, my2;
  longint y;
  bit seen_clip, seen_wrap;

  iir dut (.clk(clk), .reset_n(reset_n), .data_in(data_in), .data_out(data_out));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
  endtask

  task automatic model(input longint x, output longint r);
    longint acc;
    acc = 409495 * x + 818989 * mx1 + 409495 * mx2 + 3954428 * my1 - 1398101 * my2;
    acc = (acc + 2097152) >>> 22;
    r = acc > 8388607 ? 8388607 : acc < -8388608 ? -8388608 : acc;
    mx2 = mx1; mx1 = x; my2 = my1; my1 = r;
  endtask

  task automatic step(input longint x, input string tag, output longint r);
    data_in = 24'(x);
    @(posedge clk);
    #1;
    model(x, r);
    chk(tag, longint'(data_out), r);
  endtask

  // Asynchronous pulse placed between edges; output must clear without a clock.
  task automatic pulse_reset(input string tag);
    reset_n = 1'b0;
    #1;
    chk(tag, longint'(data_out), 0);
    #2;
    reset_n = 1'b1;
    mreset();
  endtask

  function automatic longint sine(input int i);
    return longint'($rtoi(3000000.0 * $sin(2.0 * 3.14159265 * i / 16.0)));
  endfunction

  function automatic longint iabs(input longint v);
    return v < 0 ? -v : v;
  endfunction

  initial begin
    mreset();
    data_in = 24'h123456;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("reset_out", longint'(data_out), 0);
    end
    chk("reset_state", longint'({dut.r_x1, dut.r_x2, dut.r_y1, dut.r_y2}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, "first_after_reset", y);

    step(24'sh100000, "impulse_model", y);
    chk("impulse_first", longint'(data_out), 102374);
    for (int i = 0; i < 80; i++) step(0, "impulse_tail", y);
    chk("impulse_decay", longint'(iabs(longint'(data_out)) <= 1), 1);

    pulse_reset("dc_reset");
    for (int i = 0; i < 40; i++) step(1000, "dc_step", y);
    chk("dc_settle", longint'(iabs(longint'(data_out) - 1000) <= 1), 1);

    pulse_reset("satp_reset");
    seen_clip = 0; seen_wrap = 0;
    for (int i = 0; i < 40; i++) begin
      step(8388607, "sat_pos", y);
      if (data_out == 24'sh7FFFFF) seen_clip = 1;
      if (i > 0 && data_out < 0) seen_wrap = 1;
    end
    chk("sat_pos_clip", longint'(seen_clip), 1);
    chk("sat_pos_nowrap", longint'(seen_wrap), 0);

    pulse_reset("satn_reset");
    seen_clip = 0; seen_wrap = 0;
    for (int i = 0; i < 40; i++) begin
      step(-8388608, "sat_neg", y);
      if (data_out == -24'sh800000) seen_clip = 1;
      if (data_out > 0) seen_wrap = 1;
    end
    chk("sat_neg_clip", longint'(seen_clip), 1);
    chk("sat_neg_nowrap", longint'(seen_wrap), 0);

    pulse_reset("sine_reset");
    for (int i = 0; i < 24; i++) step(sine(i), "sine_pre", y);
    pulse_reset("midstream_async");
    chk("midstream_state", longint'({dut.r_x1, dut.r_x2, dut.r_y1, dut.r_y2}), 0);
    for (int i = 24; i < 48; i++) step(sine(i), "sine_post", y);

    for (int i = 0; i < 200; i++) step(longint'($signed(24'($urandom))), "stream", y);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iir.md
# iir

Second-order (biquad) IIR filter for 24-bit signed audio samples, one sample per clock. It sits in the audio datapath of the DSP-on-FPGA lab design, between the sample source (file or ADC interface) and the sample sink. The block has fixed compile-time coefficients and no handshake: every rising clock edge consumes one input sample and produces one output sample.

## Interface
- WD_IN, 24: input sample width, two's complement.
- WD_OUT, 24: output sample width, two's complement.
- WD_COEF, 24: coefficient width, signed Q2.22.
- FRAC, 22: coefficient fractional bits.
- B0, 409495: feed-forward coefficient b0 (Butterworth low-pass, fc = fs/8).
- B1, 818989: feed-forward coefficient b1.
- B2, 409495: feed-forward coefficient b2.
- A1, -3954428: feedback coefficient a1.
- A2, 1398101: feedback coefficient a2.
- clk  input  1  single system clock, rising-edge active.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  WD_IN  signed input sample x[n]; a new sample arrives every clock.
- data_out  output  WD_OUT  signed filtered sample y[n], registered.

## Operation
- Difference equation (direct form I): y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2].
- State registers:
  - x1 and x2 hold the previous inputs, WD_IN bits each.
  - y1 and y2 hold the previous outputs, WD_OUT bits each. These are the saturated values, so the feedback path always sees exactly what appears on data_out.
- Arithmetic:
  - Each product is a full-precision signed multiply, WD_IN+WD_COEF (or WD_OUT+WD_COEF) bits.
  - The five products are summed in a signed accumulator of at least 52 bits. The accumulator must not overflow internally.
  - Rounding: add 2^(FRAC−1), then arithmetic right shift by FRAC. This is round-half-up.
- Saturation: clamp the result to the range [−2^(WD_OUT−1), 2^(WD_OUT−1)−1], i.e. 0x800000..0x7FFFFF. The output never wraps.
- Coefficients are parameters only; there is no runtime load port.
- The arithmetic is combinational from data_in and the state registers to the next-state and output registers. Multipliers may be inferred as DSP blocks.

## Timing
- At every rising clk edge with reset_n high:
  - data_out ← sat(round(acc)), computed from the current data_in;
  - x1 ← data_in and x2 ← x1;
  - y1 ← new output and y2 ← y1.
- Latency: the output for x[n] (sampled at edge n) is visible on data_out right after edge n, i.e. one register stage.
- Throughput: one sample per clock. There is no enable and no valid signal.
- Reset behaviour:
  - reset_n low immediately forces data_out, x1, x2, y1 and y2 to 0, independent of clk.
  - This also applies mid-stream: all history is discarded.
  - The first edge after release filters data_in as if all prior samples were 0.
- X or unknown values are never propagated from reset: all registers have defined reset values.

## Test plan
- **Reset:** hold reset_n low with data_in = 0x123456 and clk toggling → data_out = 0x000000 throughout; x1, x2, y1 and y2 = 0.
- **Impulse:** data_in = 0x100000 for one cycle, then 0 → the first output is 0x018FE6 (102374). Following outputs must match a bit-exact reference model using the stated rounding; the sequence decays to 0 with no residual limit cycle beyond ±1 LSB.
- **DC step:** constant data_in = 1000 → settles to 1000 ±1 within 40 samples. Small overshoot (under 5%) is allowed.
- **Saturation:**
  - constant 0x7FFFFF → data_out clamps at 0x7FFFFF during the overshoot and never wraps negative;
  - constant 0x800000 → clamps at 0x800000.
- **Reset mid-stream:** while streaming a sine, pulse reset_n low between edges → data_out goes to 0 asynchronously. After release, the response equals a fresh-start model.
- **Stream regression:** a full audio file is fed one sample per clock → data_out matches the bit-exact model sample for sample.
